mem_access_stage: RTL and testbench

- MEM stage sitting directly downstream of the execute stage; consumes the EX/MEM register fields and produces the registered MEM/WB register.
- Drives a data-memory bus with a req/gnt/rvalid handshake.
- Aligns store data to byte lanes and generates byte enables; extracts and sign/zero-extends load data.
- Stalls the upstream pipeline while a memory transaction is outstanding.

---
 rtl/mem_access_stage.sv | 234 +++++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage between the EX/MEM and MEM/WB registers.
// Drives a req/gnt/rvalid data-memory bus, aligns store data to byte lanes,
// formats load data, and stalls upstream while a bus access is in flight.
// Optional build macro: MEM_MISALIGN_TRAP_EN (misaligned half/word accesses
// are trapped in one cycle without a bus request and flagged on misalign_o).
module mem_access_stage #(
  parameter int DATA_W     = 32,
  parameter int RF_ADDRESS = 5,
  parameter int PC_W       = 9,
  parameter int DM_ADDRESS = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_aluresult,
  input  logic [DATA_W-1:0]     in_memwritedata,
  input  logic [RF_ADDRESS-1:0] in_rd,
  input  logic [PC_W-1:0]       in_pcplus4,
  input  logic                  in_regwrite,
  input  logic                  in_memread,
  input  logic                  in_memwrite,
  input  logic [1:0]            in_memtoreg,
  input  logic [2:0]            in_readdatasel,
  input  logic [1:0]            in_writedatasel,
  output logic                  stall_o,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [DM_ADDRESS-1:0] dmem_addr,
  output logic [DATA_W-1:0]     dmem_wdata,
  output logic [3:0]            dmem_be,
  input  logic                  dmem_gnt,
  input  logic                  dmem_rvalid,
  input  logic [DATA_W-1:0]     dmem_rdata,
  output logic                  wb_valid,
  output logic                  wb_regwrite,
  output logic [1:0]            wb_memtoreg,
  output logic [RF_ADDRESS-1:0] wb_rd,
  output logic [DATA_W-1:0]     wb_aluresult,
  output logic [DATA_W-1:0]     wb_readdata,
  output logic [PC_W-1:0]       wb_pcplus4
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic                  misalign_o
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  localparam logic [2:0] LW  = 3'b000;
  localparam logic [2:0] LB  = 3'b001;
  localparam logic [2:0] LH  = 3'b010;
  localparam logic [2:0] LBU = 3'b011;
  localparam logic [2:0] LHU = 3'b100;
  localparam logic [1:0] SB  = 2'b01;
  localparam logic [1:0] SH  = 2'b10;

  state_t state_q, state_d;

  logic              mem_op;
  logic              mis;
  logic [1:0]        off;
  logic [3:0]        st_be;
  logic [DATA_W-1:0] st_wdata;
  logic              cap;
  logic [DATA_W-1:0] rdata_fmt;
  logic [DATA_W-1:0] rdata_nxt;

  // Latched request, held stable on the bus until granted
  logic [DM_ADDRESS-1:0] addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [3:0]            be_q;
  logic                  we_q;
  logic [1:0]            off_q;
  logic [2:0]            rsel_q;

  // memread+memwrite together is a store, so memwrite alone picks direction
  assign mem_op = in_valid & (in_memread | in_memwrite);
  assign off    = in_aluresult[1:0];

  // Store lane alignment: replicate narrow data on every lane, select via be
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = in_memwritedata;
    case (in_writedatasel)
      SB: begin
        st_be    = 4'b0001 << off;
        st_wdata = {(DATA_W/8){in_memwritedata[7:0]}};
      end
      SH: begin
        st_be    = off[1] ? 4'b1100 : 4'b0011;
        st_wdata = {(DATA_W/16){in_memwritedata[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic acc_half, acc_word;
  // Classify access width; undefined load/store codes count as word
  always_comb begin
    acc_half = 1'b0;
    acc_word = 1'b0;
    if (in_memwrite) begin
      acc_half = (in_writedatasel == SH);
      acc_word = (in_writedatasel != SH) && (in_writedatasel != SB);
    end else begin
      acc_half = (in_readdatasel == LH) || (in_readdatasel == LHU);
      acc_word = !acc_half && (in_readdatasel != LB) && (in_readdatasel != LBU);
    end
  end
  assign mis = mem_op & ((acc_half & off[0]) | (acc_word & (off != 2'b00)));
`else
  assign mis = 1'b0;
`endif

  // Load formatting from the latched lane offset and load type
  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    b         = dmem_rdata[8*off_q +: 8];
    h         = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    rdata_fmt = dmem_rdata;
    case (rsel_q)
      LB:      rdata_fmt = {{(DATA_W-8){b[7]}}, b};
      LBU:     rdata_fmt = {{(DATA_W-8){1'b0}}, b};
      LH:      rdata_fmt = {{(DATA_W-16){h[15]}}, h};
      LHU:     rdata_fmt = {{(DATA_W-16){1'b0}}, h};
      default: rdata_fmt = dmem_rdata;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state, stall and MEM/WB capture strobe
  always_comb begin
    state_d   = state_q;
    stall_o   = 1'b0;
    cap       = 1'b0;
    rdata_nxt = '0;
    case (state_q)
      IDLE: begin
        if (mem_op && !mis) begin
          stall_o = 1'b1;
          state_d = REQ;
        end else begin
          cap = 1'b1;
        end
      end
      REQ: begin
        if (dmem_gnt && we_q) begin
          cap     = 1'b1;
          state_d = IDLE;
        end else if (dmem_gnt) begin
          stall_o = 1'b1;
          state_d = RESP;
        end else begin
          stall_o = 1'b1;
        end
      end
      RESP: begin
        if (dmem_rvalid) begin
          cap       = 1'b1;
          rdata_nxt = rdata_fmt;
          state_d   = IDLE;
        end else begin
          stall_o = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dmem_req   = (state_q == REQ);
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign dmem_be    = be_q;

  // Latch the bus request when an access launches from IDLE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      off_q   <= '0;
      rsel_q  <= '0;
    end else if (state_q == IDLE && mem_op) begin
      addr_q  <= in_aluresult[DM_ADDRESS+1:2];
      wdata_q <= st_wdata;
      be_q    <= st_be;
      we_q    <= in_memwrite;
      off_q   <= off;
      rsel_q  <= in_readdatasel;
    end
  end

  // MEM/WB register; stalled cycles emit a bubble so WB never repeats a write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_valid     <= 1'b0;
      wb_regwrite  <= 1'b0;
      wb_memtoreg  <= '0;
      wb_rd        <= '0;
      wb_aluresult <= '0;
      wb_readdata  <= '0;
      wb_pcplus4   <= '0;
    end else if (cap) begin
      wb_valid     <= in_valid;
      wb_regwrite  <= in_valid & in_regwrite & ~mis;
      wb_memtoreg  <= in_memtoreg;
      wb_rd        <= in_rd;
      wb_aluresult <= in_aluresult;
      wb_readdata  <= rdata_nxt;
      wb_pcplus4   <= in_pcplus4;
    end else begin
      wb_valid    <= 1'b0;
      wb_regwrite <= 1'b0;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  // One-cycle trap flag, aligned with the MEM/WB capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) misalign_o <= 1'b0;
    else        misalign_o <= cap & mis;
  end
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed + randomized bench for mem_access_stage with
// an arithmetic reference model of lane alignment and load extension.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_aluresult, in_memwritedata;
  logic [4:0]  in_rd;
  logic [8:0]  in_pcplus4;
  logic        in_regwrite, in_memread, in_memwrite;
  logic [1:0]  in_memtoreg;
  logic [2:0]  in_readdatasel;
  logic [1:0]  in_writedatasel;
  logic        stall_o, dmem_req, dmem_we;
  logic [8:0]  dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_valid, wb_regwrite;
  logic [1:0]  wb_memtoreg;
  logic [4:0]  wb_rd;
  logic [31:0] wb_aluresult, wb_readdata;
  logic [8:0]  wb_pcplus4;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign_o;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_access_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_aluresult(in_aluresult),
    .in_memwritedata(in_memwritedata), .in_rd(in_rd), .in_pcplus4(in_pcplus4),
    .in_regwrite(in_regwrite), .in_memread(in_memread), .in_memwrite(in_memwrite),
    .in_memtoreg(in_memtoreg), .in_readdatasel(in_readdatasel),
    .in_writedatasel(in_writedatasel), .stall_o(stall_o), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_regwrite(wb_regwrite),
    .wb_memtoreg(wb_memtoreg), .wb_rd(wb_rd), .wb_aluresult(wb_aluresult),
    .wb_readdata(wb_readdata), .wb_pcplus4(wb_pcplus4)
`ifdef MEM_MISALIGN_TRAP_EN
    , .misalign_o(misalign_o)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: load value from the word, lane offset and load type
  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [1:0] off,
                                         input logic [2:0] sel);
    logic [31:0] b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * off[1])) & 32'hFFFF;
    case (sel)
      3'd1:    return (b >= 32'd128)   ? b - 32'd256   : b;
      3'd3:    return b;
      3'd2:    return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd4:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] m_be(input logic [1:0] wsel, input logic [1:0] off);
    if (wsel == 2'd1) return 32'd1 << off;
    if (wsel == 2'd2) return (off >= 2'd2) ? 32'hC : 32'h3;
    return 32'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] wsel, input logic [31:0] d);
    if (wsel == 2'd1) return (d & 32'hFF) * 32'h0101_0101;
    if (wsel == 2'd2) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic m_mis(input logic st, input logic [2:0] rsel,
                                 input logic [1:0] wsel, input logic [1:0] off);
`ifdef MEM_MISALIGN_TRAP_EN
    int size;  // access size in bytes
    if (st) size = (wsel == 2'd1) ? 1 : (wsel == 2'd2) ? 2 : 4;
    else    size = (rsel == 3'd1 || rsel == 3'd3) ? 1 :
                   (rsel == 3'd2 || rsel == 3'd4) ? 2 : 4;
    return (off % size) != 0;
`else
    return 1'b0;
`endif
  endfunction

  // One instruction through the stage: drive, act as memory, check bus and MEM/WB
  task automatic run_op(input string tag, input logic v, input logic [31:0] alu,
                        input logic [31:0] wd, input logic [4:0] rd, input logic [8:0] pc4,
                        input logic rw, input logic mr, input logic mw, input logic [1:0] mtr,
                        input logic [2:0] rsel, input logic [1:0] wsel,
                        input int gw, input int rvw, input logic [31:0] rdata);
    logic memop, mis;
    logic [31:0] exp_rd;
    @(negedge clk);
    in_valid = v; in_aluresult = alu; in_memwritedata = wd; in_rd = rd;
    in_pcplus4 = pc4; in_regwrite = rw; in_memread = mr; in_memwrite = mw;
    in_memtoreg = mtr; in_readdatasel = rsel; in_writedatasel = wsel;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    #1;
    memop  = v && (mr || mw);
    mis    = memop && m_mis(mw, rsel, wsel, alu[1:0]);
    exp_rd = 32'd0;
    if (!memop || mis) begin
      chk({tag, ".stall0"}, 32'(stall_o), 32'd0);
      chk({tag, ".noreq"}, 32'(dmem_req), 32'd0);
    end else begin
      chk({tag, ".stall_launch"}, 32'(stall_o), 32'd1);
      chk({tag, ".req_launch"}, 32'(dmem_req), 32'd0);
      for (int w = 0; w <= gw; w++) begin
        @(negedge clk);
        dmem_gnt = (w == gw);
        #1;
        chk({tag, ".req"}, 32'(dmem_req), 32'd1);
        chk({tag, ".we"}, 32'(dmem_we), 32'(mw));
        chk({tag, ".addr"}, 32'(dmem_addr), (alu >> 2) & 32'h1FF);
        if (mw) begin
          chk({tag, ".be"}, 32'(dmem_be), m_be(wsel, alu[1:0]));
          chk({tag, ".wdata"}, dmem_wdata, m_wdata(wsel, wd));
        end
        chk({tag, ".stall_req"}, 32'(stall_o), (w == gw && mw) ? 32'd0 : 32'd1);
      end
      if (!mw) begin
        for (int r = 0; r <= rvw; r++) begin
          @(negedge clk);
          dmem_gnt    = 1'b0;
          dmem_rvalid = (r == rvw);
          dmem_rdata  = (r == rvw) ? rdata : $urandom;
          #1;
          chk({tag, ".req_resp"}, 32'(dmem_req), 32'd0);
          chk({tag, ".stall_resp"}, 32'(stall_o), (r == rvw) ? 32'd0 : 32'd1);
        end
        exp_rd = m_load(rdata, alu[1:0], rsel);
      end
    end
    @(negedge clk);
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; in_valid = 1'b0;
    chk({tag, ".wb_valid"}, 32'(wb_valid), 32'(v));
    chk({tag, ".wb_regwrite"}, 32'(wb_regwrite), 32'(v && rw && !mis));
    chk({tag, ".wb_readdata"}, wb_readdata, exp_rd);
    if (v) begin
      chk({tag, ".wb_rd"}, 32'(wb_rd), 32'(rd));
      chk({tag, ".wb_alu"}, wb_aluresult, alu);
      chk({tag, ".wb_pc4"}, 32'(wb_pcplus4), 32'(pc4));
      chk({tag, ".wb_mtr"}, 32'(wb_memtoreg), 32'(mtr));
    end
`ifdef MEM_MISALIGN_TRAP_EN
    chk({tag, ".misalign"}, 32'(misalign_o), 32'(mis));
`endif
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_aluresult = '0; in_memwritedata = '0;
    in_rd = '0; in_pcplus4 = '0; in_regwrite = 1'b0; in_memread = 1'b0;
    in_memwrite = 1'b0; in_memtoreg = '0; in_readdatasel = '0; in_writedatasel = '0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    #1;
    chk("rst.req", 32'(dmem_req), 32'd0);
    chk("rst.wb_valid", 32'(wb_valid), 32'd0);
    chk("rst.wb_alu", wb_aluresult, 32'd0);
    chk("rst.wb_readdata", wb_readdata, 32'd0);
    chk("rst.stall", 32'(stall_o), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Directed cases
    run_op("alu",  1, 32'h1234, 0, 5, 9'h10, 1, 0, 0, 2'd0, 3'd0, 2'd0, 0, 0, 0);
    run_op("sb",   1, 32'h0000_0103, 32'h55AB, 0, 9'h14, 0, 0, 1, 2'd0, 3'd0, 2'd1, 2, 0, 0);
    run_op("sh",   1, 32'h0000_0022, 32'hBEEF, 0, 9'h18, 0, 0, 1, 2'd0, 3'd0, 2'd2, 0, 0, 0);
    run_op("lb",   1, 32'h2, 0, 7, 9'h1C, 1, 1, 0, 2'd1, 3'd1, 2'd0, 0, 0, 32'h0080_0000);
    run_op("lbu",  1, 32'h2, 0, 7, 9'h20, 1, 1, 0, 2'd1, 3'd3, 2'd0, 1, 0, 32'h0080_0000);
    run_op("lh",   1, 32'h2, 0, 8, 9'h24, 1, 1, 0, 2'd1, 3'd2, 2'd0, 0, 2, 32'h8001_1234);
    run_op("lw",   1, 32'h2, 0, 8, 9'h28, 1, 1, 0, 2'd1, 3'd0, 2'd0, 0, 0, 32'h8001_1234);
    run_op("lw6",  1, 32'h6, 0, 9, 9'h2C, 1, 1, 0, 2'd1, 3'd0, 2'd0, 1, 1, 32'hCAFE_F00D);
    run_op("bub",  0, 32'h44, 0, 3, 9'h30, 1, 1, 0, 2'd1, 3'd0, 2'd0, 0, 0, 0);
    run_op("rwst", 1, 32'h48, 32'h77, 4, 9'h34, 0, 1, 1, 2'd0, 3'd0, 2'd0, 0, 0, 0);

    // Reset while a load waits for its response
    @(negedge clk);
    in_valid = 1; in_aluresult = 32'h80; in_memread = 1; in_memwrite = 0;
    in_readdatasel = 3'd0; in_regwrite = 1; in_rd = 6;
    @(negedge clk); dmem_gnt = 1'b1;
    @(negedge clk); dmem_gnt = 1'b0;
    #1;
    chk("mid.in_resp_stall", 32'(stall_o), 32'd1);
    reset = 1'b0; in_valid = 1'b0;
    #1;
    chk("mid.req", 32'(dmem_req), 32'd0);
    chk("mid.wb_valid", 32'(wb_valid), 32'd0);
    chk("mid.wb_alu", wb_aluresult, 32'd0);
    chk("mid.stall", 32'(stall_o), 32'd0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_2222;
    #1;
    chk("late.stall", 32'(stall_o), 32'd0);
    chk("late.req", 32'(dmem_req), 32'd0);
    @(negedge clk); dmem_rvalid = 1'b0;
    chk("late.wb_valid", 32'(wb_valid), 32'd0);
    chk("late.wb_readdata", wb_readdata, 32'd0);

    // Randomized mix
    for (int i = 0; i < 60; i++) begin
      int kind;
      logic [31:0] a;
      kind = $urandom_range(0, 3);
      a    = $urandom;
      case (kind)
        0: run_op("r.alu", 1, a, $urandom, 5'($urandom), 9'($urandom), 1'($urandom), 0, 0,
                  2'($urandom), 3'($urandom), 2'($urandom), 0, 0, 0);
        1: run_op("r.ld", 1, a, $urandom, 5'($urandom), 9'($urandom), 1'($urandom), 1, 0,
                  2'($urandom), 3'($urandom_range(0, 7)), 2'($urandom),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
        2: run_op("r.st", 1, a, $urandom, 5'($urandom), 9'($urandom), 1'($urandom),
                  1'($urandom), 1, 2'($urandom), 3'($urandom), 2'($urandom_range(0, 3)),
                  $urandom_range(0, 3), 0, 0);
        default: run_op("r.bub", 0, a, $urandom, 5'($urandom), 9'($urandom), 1,
                  1'($urandom), 1'($urandom), 2'($urandom), 3'($urandom), 2'($urandom),
                  0, 0, 0);
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
